// File: rtl/fifo_ring_pkg.sv
// Shared constants and width helpers for the fifo_ring_buffer block.
package fifo_ring_pkg;

   localparam int MIN_DEPTH = 4;

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   // One extra bit so the count can represent a completely full ring.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_ring_buffer_if.sv
// Producer/consumer handshake bundle for fifo_ring_buffer.
interface fifo_ring_buffer_if #(
   parameter int RAM_WIDTH = 32,
   parameter int RAM_DEPTH = 256
);
   import fifo_ring_pkg::*;

   localparam int CW = cnt_w(RAM_DEPTH);

   logic                 i_wr_valid;
   logic [RAM_WIDTH-1:0] i_wr_data;
   logic                 i_rd_en;
   logic                 o_rd_valid;
   logic [RAM_WIDTH-1:0] o_rd_data;
   logic                 o_ready;
   logic                 o_empty;
   logic                 o_empty_next;
   logic                 o_full;
   logic                 o_full_next;
   logic [CW-1:0]        o_fill_count;

   modport master (
      output i_wr_valid, i_wr_data, i_rd_en,
      input  o_rd_valid, o_rd_data, o_ready, o_empty, o_empty_next,
             o_full, o_full_next, o_fill_count
   );

   modport slave (
      input  i_wr_valid, i_wr_data, i_rd_en,
      output o_rd_valid, o_rd_data, o_ready, o_empty, o_empty_next,
             o_full, o_full_next, o_fill_count
   );

endinterface

// File: rtl/fifo_ring_mem.sv
// Storage array for the ring FIFO: one synchronous write port, one combinational read port.
module fifo_ring_mem #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Contents are deliberately left unreset; occupancy alone says what is valid.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_ring_buffer.sv
// First-word-fall-through ring FIFO with fill count and early-warning flags.
// Define FIFO_RING_ASSERT_EN to compile in the internal SVA consistency checks.
module fifo_ring_buffer
   import fifo_ring_pkg::*;
#(
   parameter int RAM_WIDTH = 32,
   parameter int RAM_DEPTH = 256
) (
   input  logic              clk,
   input  logic              rst,
   fifo_ring_buffer_if.slave bus
);

   localparam int PW = ptr_w(RAM_DEPTH);
   localparam int CW = cnt_w(RAM_DEPTH);

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   ptr_t                 head;
   ptr_t                 tail;
   cnt_t                 count;
   logic                 empty;
   logic                 full;
   logic                 wr_acc;
   logic                 rd_acc;
   logic [RAM_WIDTH-1:0] head_word;

   assign empty  = (count == '0);
   assign full   = (count == CW'(RAM_DEPTH));
   assign wr_acc = bus.i_wr_valid && !full;
   assign rd_acc = bus.i_rd_en && !empty;

   // Pointers are exactly PW bits wide, so the power-of-two depth wraps for free.
   always_ff @(posedge clk) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (wr_acc) head <= head + ptr_t'(1);
         if (rd_acc) tail <= tail + ptr_t'(1);
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + cnt_t'(1);
            2'b01:   count <= count - cnt_t'(1);
            default: count <= count;
         endcase
      end
   end

   fifo_ring_mem #(
      .WIDTH (RAM_WIDTH),
      .DEPTH (RAM_DEPTH),
      .AW    (PW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc && rst),
      .waddr (head),
      .wdata (bus.i_wr_data),
      .raddr (tail),
      .rdata (head_word)
   );

   assign bus.o_rd_valid   = !empty;
   assign bus.o_rd_data    = empty ? '0 : head_word;
   assign bus.o_ready      = rst && !full;
   assign bus.o_empty      = empty;
   assign bus.o_empty_next = (count <= cnt_t'(1));
   assign bus.o_full       = full;
   assign bus.o_full_next  = (count >= cnt_t'(RAM_DEPTH - 1));
   assign bus.o_fill_count = count;

`ifdef FIFO_RING_ASSERT_EN
   a_count_max: assert property (@(posedge clk) disable iff (!rst)
      count <= cnt_t'(RAM_DEPTH));

   a_count_no_underflow: assert property (@(posedge clk) disable iff (!rst)
      (count == '0) |=> (count <= cnt_t'(1)));

   a_flags_excl: assert property (@(posedge clk) disable iff (!rst)
      !(full && empty));

   a_count_ptrs: assert property (@(posedge clk) disable iff (!rst)
      count == (full ? cnt_t'(RAM_DEPTH) : cnt_t'(ptr_t'(head - tail))));

   a_reset_hold: assert property (@(posedge clk)
      !rst |=> (head == '0 && tail == '0 && count == '0));
`endif

endmodule

// File: tb/tb_fifo_ring_buffer.sv
// Self-checking bench for fifo_ring_buffer: vector table plus queue scoreboard.
module tb_fifo_ring_buffer;

   localparam int W     = 32;
   localparam int DEPTH = 256;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic clk;
   logic rst;

   fifo_ring_buffer_if #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH)) bus ();

   fifo_ring_buffer #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   logic [W-1:0] mq [$];

   typedef struct {
      logic         wv;
      logic [W-1:0] wd;
      logic         re;
      int           cnt;
      logic         empty;
      logic         empty_next;
      logic [W-1:0] data;
   } vec_t;

   vec_t tbl [9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Drive one cycle, update the scoreboard at the edge, then compare all outputs.
   task automatic apply(input logic r, input logic wv, input logic [W-1:0] wd, input logic re);
      logic wacc, racc;
      logic [W-1:0] exp_data;
      int n;
      rst            = r;
      bus.i_wr_valid = wv;
      bus.i_wr_data  = wd;
      bus.i_rd_en    = re;
      #1;
      wacc = r && wv && (mq.size() < DEPTH);
      racc = r && re && (mq.size() > 0);
      if (racc) check("pop_data", {32'h0, bus.o_rd_data}, {32'h0, mq[0]});
      @(posedge clk);
      if (!r) mq.delete();
      else begin
         if (racc) void'(mq.pop_front());
         if (wacc) mq.push_back(wd);
      end
      #1;
      n = mq.size();
      exp_data = (n > 0) ? mq[0] : '0;
      check("fill_count", 64'(bus.o_fill_count), 64'(n));
      check("rd_valid",   64'(bus.o_rd_valid),   64'(n != 0));
      check("rd_data",    64'(bus.o_rd_data),    64'(exp_data));
      check("empty",      64'(bus.o_empty),      64'(n == 0));
      check("empty_next", 64'(bus.o_empty_next), 64'(n <= 1));
      check("full",       64'(bus.o_full),       64'(n == DEPTH));
      check("full_next",  64'(bus.o_full_next),  64'(n >= DEPTH - 1));
      check("ready",      64'(bus.o_ready),      64'(r && (n < DEPTH)));
   endtask

   initial begin
      rst = 1'b0;
      bus.i_wr_valid = 1'b0;
      bus.i_wr_data  = '0;
      bus.i_rd_en    = 1'b0;

      tbl[0] = '{1'b1, 32'hA1, 1'b0, 1, 1'b0, 1'b1, 32'hA1};
      tbl[1] = '{1'b1, 32'hB2, 1'b0, 2, 1'b0, 1'b0, 32'hA1};
      tbl[2] = '{1'b0, 32'h0,  1'b1, 1, 1'b0, 1'b1, 32'hB2};
      tbl[3] = '{1'b1, 32'hC3, 1'b1, 1, 1'b0, 1'b1, 32'hC3};
      tbl[4] = '{1'b0, 32'h0,  1'b1, 0, 1'b1, 1'b1, 32'h0};
      tbl[5] = '{1'b0, 32'h0,  1'b1, 0, 1'b1, 1'b1, 32'h0};
      tbl[6] = '{1'b1, 32'hD4, 1'b1, 1, 1'b0, 1'b1, 32'hD4};
      tbl[7] = '{1'b0, 32'h0,  1'b0, 1, 1'b0, 1'b1, 32'hD4};
      tbl[8] = '{1'b0, 32'h0,  1'b1, 0, 1'b1, 1'b1, 32'h0};

      // Reset held 20 cycles with write/read traffic that must be ignored.
      for (int i = 0; i < 20; i++) apply(1'b0, i[0], W'(i + 500), ~i[0]);
      check("reset_ready_low", 64'(bus.o_ready), 64'(0));
      apply(1'b1, 1'b0, '0, 1'b0);
      check("release_ready", 64'(bus.o_ready), 64'(1));

      // Table of short read/write patterns from empty.
      for (int i = 0; i < 9; i++) begin
         apply(1'b1, tbl[i].wv, tbl[i].wd, tbl[i].re);
         check("tbl_count",      64'(bus.o_fill_count), 64'(tbl[i].cnt));
         check("tbl_empty",      64'(bus.o_empty),      64'(tbl[i].empty));
         check("tbl_empty_next", 64'(bus.o_empty_next), 64'(tbl[i].empty_next));
         check("tbl_data",       64'(bus.o_rd_data),    64'(tbl[i].data));
      end

      // Burst fill 1..256.
      for (int i = 1; i <= DEPTH; i++) begin
         apply(1'b1, 1'b1, W'(i), 1'b0);
         if (i == DEPTH - 1) begin
            check("burst_full_next", 64'(bus.o_full_next), 64'(1));
            check("burst_not_full",  64'(bus.o_full),      64'(0));
         end
      end
      check("burst_full",  64'(bus.o_full),       64'(1));
      check("burst_ready", 64'(bus.o_ready),      64'(0));
      check("burst_count", 64'(bus.o_fill_count), 64'(DEPTH));

      // Overflow write is dropped.
      apply(1'b1, 1'b1, W'(999), 1'b0);
      check("ovf_count", 64'(bus.o_fill_count), 64'(DEPTH));

      // Drain: scoreboard checks 1..256 in order via pop_data.
      for (int i = 1; i <= DEPTH; i++) begin
         check("drain_word", 64'(bus.o_rd_data), 64'(i));
         apply(1'b1, 1'b0, '0, 1'b1);
      end
      check("drain_valid", 64'(bus.o_rd_valid), 64'(0));
      check("drain_empty", 64'(bus.o_empty),    64'(1));
      check("drain_data",  64'(bus.o_rd_data),  64'(0));

      // Advance pointers near the wrap point, then sparse writes across it.
      apply(1'b1, 1'b1, W'(32'h1000), 1'b0);
      for (int i = 0; i < 240; i++) apply(1'b1, 1'b1, W'(32'h2000 + i), 1'b1);
      apply(1'b1, 1'b0, '0, 1'b1);
      for (int k = 1; k <= 30; k++) begin
         apply(1'b1, 1'b1, W'(32'h5000 + k), 1'b0);
         check("sparse_count", 64'(bus.o_fill_count), 64'(k));
         if (k == 2) check("sparse_empty_next", 64'(bus.o_empty_next), 64'(0));
         repeat (11) apply(1'b1, 1'b0, '0, 1'b0);
      end
      while (mq.size() > 0) apply(1'b1, 1'b0, '0, 1'b1);

      // Simultaneous read/write at count 5 keeps count and order.
      for (int i = 0; i < 5; i++) apply(1'b1, 1'b1, W'(32'h700 + i), 1'b0);
      apply(1'b1, 1'b1, W'(32'h7FF), 1'b1);
      check("rw5_count", 64'(bus.o_fill_count), 64'(5));
      check("rw5_head",  64'(bus.o_rd_data),    64'(32'h701));
      while (mq.size() > 0) apply(1'b1, 1'b0, '0, 1'b1);

      // Simultaneous read/write on empty.
      apply(1'b1, 1'b1, W'(32'h88), 1'b1);
      check("rw_empty_count", 64'(bus.o_fill_count), 64'(1));
      apply(1'b1, 1'b0, '0, 1'b1);

      // Reset at count 100 wins over concurrent read/write.
      for (int i = 0; i < 100; i++) apply(1'b1, 1'b1, W'(i + 1), 1'b0);
      check("pre_reset_count", 64'(bus.o_fill_count), 64'(100));
      apply(1'b0, 1'b1, W'(32'hDEAD), 1'b1);
      check("mid_reset_count", 64'(bus.o_fill_count), 64'(0));
      check("mid_reset_empty", 64'(bus.o_empty),      64'(1));
      check("mid_reset_data",  64'(bus.o_rd_data),    64'(0));
      apply(1'b1, 1'b0, '0, 1'b0);
      check("post_reset_ready", 64'(bus.o_ready), 64'(1));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
